// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
//   Shared constants and types for the sprite ROM reader path.
//   Optional feature macro: TILE_MIRROR_EN (adds the row bit-reverse helper).
//
//   TILES_PER_LINE : tiles across one active line (640 / 32)
//   TILE_W         : pixels per tile row, equal to the ROM data width
//   ROW_W          : row-in-tile index bits (DrawY[4:0])
//   TILE_ID_W      : tile id bits returned by the tilemap
//   ADDR_W         : sprite ROM address width, {tile_id, row}
//   COL_W          : tile column / tile counter width
//   BIT_W          : pixel-in-tile counter width
//   Y_W            : scanline number width
// ---------------------------------------------------------------------------
package sprite_pkg;

  localparam int TILES_PER_LINE = 20;
  localparam int TILE_W         = 32;
  localparam int ROW_W          = 5;
  localparam int TILE_ID_W      = 1;
  localparam int ADDR_W         = TILE_ID_W + ROW_W;
  localparam int COL_W          = 5;
  localparam int BIT_W          = $clog2(TILE_W);
  localparam int Y_W            = 10;

  // Fetch FSM encoding, also visible on the debug state port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ROM  = 2'd2,
    FULL = 2'd3
  } fetch_state_t;

  typedef logic [TILE_W-1:0] tile_row_t;

`ifdef TILE_MIRROR_EN
  // Horizontal flip of a tile row: bit 0 becomes the first pixel shown.
  function automatic tile_row_t reverse_row(input tile_row_t row);
    tile_row_t rev;
    for (int i = 0; i < TILE_W; i++) begin
      rev[i] = row[TILE_W-1-i];
    end
    return rev;
  endfunction
`endif

endpackage

// File: rtl/tile_row_shifter.sv
// ---------------------------------------------------------------------------
// tile_row_shifter
//   Pixel side of the tile reader. Holds the row currently being shown
//   (shift register) and the prefetched row (next_row buffer), swaps them
//   at each tile boundary and shifts pixels out MSB-first, one per pix_en.
//
//   Ports
//     i_clk, i_reset   : clock, synchronous active-high reset
//     i_line_start     : start of active line; clears buffers and counters
//     i_pix_en         : pixel strobe
//     i_capture        : fetch side presents a ROM row this cycle
//     i_cap_row        : the row being captured (already mirrored if needed)
//     o_swap           : tile boundary this cycle (shift reloads)
//     o_cap_direct     : the captured row goes straight into the shift
//                        register (priming or bypass), not into next_row
//     o_pixel_out      : registered pixel
//     o_pixel_valid    : o_pixel_out carries a new pixel this cycle
//     o_underrun       : sticky per line; a boundary found no row ready
// ---------------------------------------------------------------------------
module tile_row_shifter
  import sprite_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_line_start,
  input  logic              i_pix_en,
  input  logic              i_capture,
  input  logic [TILE_W-1:0] i_cap_row,
  output logic              o_swap,
  output logic              o_cap_direct,
  output logic              o_pixel_out,
  output logic              o_pixel_valid,
  output logic              o_underrun
);

  logic [TILE_W-1:0] r_shift;
  logic [TILE_W-1:0] r_next;
  logic              r_next_valid;
  logic              r_primed;      // shift register has received its first row
  logic              r_active;      // line still has pixels left to emit
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [COL_W-1:0]  r_tile_cnt;
  logic              r_pixel_out;
  logic              r_pixel_valid;
  logic              r_underrun;

  logic w_fire;
  logic w_end_tile;
  logic w_last_tile;
  logic w_swap;

  assign w_fire      = i_pix_en & r_active & ~i_line_start;
  assign w_end_tile  = (r_bit_cnt == BIT_W'(TILE_W - 1));
  assign w_last_tile = (r_tile_cnt == COL_W'(TILES_PER_LINE - 1));
  // No reload after the final tile: nothing follows it, so it must not
  // be mistaken for an underrun.
  assign w_swap      = w_fire & w_end_tile & ~w_last_tile;

  // The fetch side only captures while next_row is empty, so a captured
  // row either lands in the empty next_row, or feeds the shift register
  // directly when it is the first row of the line or arrives exactly on
  // the boundary that needs it.
  assign o_cap_direct = i_capture & (w_swap | ~r_primed);
  assign o_swap       = w_swap;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift       <= '0;
      r_next        <= '0;
      r_next_valid  <= 1'b0;
      r_primed      <= 1'b0;
      r_active      <= 1'b0;
      r_bit_cnt     <= '0;
      r_tile_cnt    <= '0;
      r_pixel_out   <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_underrun    <= 1'b0;
    end else if (i_line_start) begin
      r_shift       <= '0;
      r_next        <= '0;
      r_next_valid  <= 1'b0;
      r_primed      <= 1'b0;
      r_active      <= 1'b1;
      r_bit_cnt     <= '0;
      r_tile_cnt    <= '0;
      r_pixel_valid <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_pixel_valid <= w_fire;
      if (w_fire) begin
        r_pixel_out <= r_shift[TILE_W-1];
        r_bit_cnt   <= r_bit_cnt + 1'b1;
        if (w_end_tile) begin
          if (w_last_tile) begin
            r_active <= 1'b0;
          end else begin
            r_tile_cnt <= r_tile_cnt + 1'b1;
          end
        end
      end

      if (w_swap) begin
        r_primed <= 1'b1;
        if (r_next_valid) begin
          r_shift      <= r_next;
          r_next_valid <= 1'b0;
        end else if (i_capture) begin
          r_shift <= i_cap_row;
        end else begin
          // Row missing: show a blank tile. The fetch still in flight
          // lands in next_row and is shown one tile late.
          r_shift    <= '0;
          r_underrun <= 1'b1;
        end
      end else if (i_capture && !r_primed) begin
        r_shift  <= i_cap_row;
        r_primed <= 1'b1;
      end else begin
        if (w_fire) begin
          r_shift <= {r_shift[TILE_W-2:0], 1'b0};
        end
        if (i_capture) begin
          r_next       <= i_cap_row;
          r_next_valid <= 1'b1;
        end
      end
    end
  end

  assign o_pixel_out   = r_pixel_out;
  assign o_pixel_valid = r_pixel_valid;
  assign o_underrun    = r_underrun;

endmodule

// File: rtl/tile_row_reader.sv
// ---------------------------------------------------------------------------
// tile_row_reader
//   Reader side of the sprite ROM. For each tile column of the active line
//   it asks the tilemap for the tile id, addresses the sprite ROM with
//   {tile_id, DrawY[4:0]}, captures the 32-bit row and hands it to
//   tile_row_shifter, which streams it MSB-first one pixel per pix_en.
//   The next tile's row is fetched while the current one shifts.
//   Optional feature macro: TILE_MIRROR_EN (adds map_mirror; a set mirror
//   flag bit-reverses the captured row).
//
//   Ports
//     Clk, Reset   : clock, synchronous active-high reset
//     line_start   : 1-cycle pulse at start of active line
//     DrawY        : current scanline, stable for the whole line
//     pix_en       : pixel strobe
//     map_req      : tilemap request
//     map_col      : tile column requested
//     map_row      : tile row requested (DrawY[9:5])
//     map_ack      : tilemap answer; map_tile_id valid this cycle
//     map_tile_id  : tile id
//     map_mirror   : (TILE_MIRROR_EN only) flip this tile horizontally
//     rom_addr     : sprite ROM address
//     rom_data     : sprite ROM row, combinational from rom_addr
//     pixel_out    : current pixel
//     pixel_valid  : pixel_out valid this cycle
//     underrun     : sticky per line, row not ready at a tile boundary
//     o_dbg_state  : fetch FSM state (fetch_state_t encoding)
// ---------------------------------------------------------------------------
module tile_row_reader
  import sprite_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 line_start,
  input  logic [Y_W-1:0]       DrawY,
  input  logic                 pix_en,
  output logic                 map_req,
  output logic [COL_W-1:0]     map_col,
  output logic [4:0]           map_row,
  input  logic                 map_ack,
  input  logic [TILE_ID_W-1:0] map_tile_id,
`ifdef TILE_MIRROR_EN
  input  logic                 map_mirror,
`endif
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [TILE_W-1:0]    rom_data,
  output logic                 pixel_out,
  output logic                 pixel_valid,
  output logic                 underrun,
  output logic [1:0]           o_dbg_state
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;

  logic [COL_W-1:0]     r_col;       // column being fetched
  logic [Y_W-1:0]       r_y;         // scanline latched at line_start
  logic [TILE_ID_W-1:0] r_tile_id;

  logic              w_capture;
  logic              w_last_col;
  logic              w_swap;
  logic              w_cap_direct;
  logic [TILE_W-1:0] w_cap_row;

  // Tilemap handshake: map_req is the valid. While it is high, map_col
  // and map_row do not change. map_ack is the ready: the request completes
  // in the cycle where map_req and map_ack are both high, and map_tile_id
  // (plus map_mirror when present) is sampled in that same cycle. map_ack
  // outside a request is ignored.

  // A line_start in ROM abandons that row; it belongs to the old line.
  assign w_capture  = (r_state == ROM) && !line_start;
  assign w_last_col = (r_col == COL_W'(TILES_PER_LINE - 1));

`ifdef TILE_MIRROR_EN
  logic r_mirror;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_mirror <= 1'b0;
    end else if (r_state == REQ && map_ack) begin
      r_mirror <= map_mirror;
    end
  end

  assign w_cap_row = r_mirror ? reverse_row(rom_data) : rom_data;
`else
  assign w_cap_row = rom_data;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: w_next_state = IDLE;
      REQ: begin
        if (map_ack) begin
          w_next_state = ROM;
        end
      end
      ROM: begin
        // A row consumed directly by the shifter leaves next_row free,
        // so the following column can be requested at once.
        if (w_cap_direct) begin
          w_next_state = w_last_col ? IDLE : REQ;
        end else begin
          w_next_state = FULL;
        end
      end
      FULL: begin
        if (w_swap) begin
          w_next_state = w_last_col ? IDLE : REQ;
        end
      end
      default: w_next_state = IDLE;
    endcase
    if (line_start) begin
      w_next_state = REQ;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    map_req     = (r_state == REQ);
    map_col     = r_col;
    map_row     = r_y[Y_W-1:ROW_W];
    rom_addr    = '0;
    if (r_state == ROM) begin
      rom_addr = {r_tile_id, r_y[ROW_W-1:0]};
    end
    o_dbg_state = r_state;
  end

  // ---------------- fetch datapath ----------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_col     <= '0;
      r_y       <= '0;
      r_tile_id <= '0;
    end else if (line_start) begin
      r_col <= '0;
      r_y   <= DrawY;
    end else begin
      if (r_state == REQ && map_ack) begin
        r_tile_id <= map_tile_id;
      end
      // Every entry into REQ other than line_start moves to the next column.
      if (r_state != REQ && w_next_state == REQ) begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  tile_row_shifter u_shifter (
    .i_clk         (Clk),
    .i_reset       (Reset),
    .i_line_start  (line_start),
    .i_pix_en      (pix_en),
    .i_capture     (w_capture),
    .i_cap_row     (w_cap_row),
    .o_swap        (w_swap),
    .o_cap_direct  (w_cap_direct),
    .o_pixel_out   (pixel_out),
    .o_pixel_valid (pixel_valid),
    .o_underrun    (underrun)
  );

endmodule
